// File: rtl/alu_scheduler.sv
// alu_scheduler: arbitrates two requesters onto one registered external ALU.
// Illegal or divide-by-zero operations are answered directly with an error response
// and never reach the ALU.
module alu_scheduler #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [3:0]       req0_op_i,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,

    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [3:0]       req1_op_i,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,

    output logic             resp0_valid_o,
    input  logic             resp0_ready_i,
    output logic             resp1_valid_o,
    input  logic             resp1_ready_i,
    output logic [WIDTH-1:0] resp_data_o,
    output logic             resp_zr_o,
    output logic             resp_neg_o,
    output logic             resp_err_o,

    output logic [3:0]       alu_ctrl_o,
    output logic [WIDTH-1:0] alu_in1_o,
    output logic [WIDTH-1:0] alu_in2_o,
    input  logic [WIDTH-1:0] alu_out_i,
    input  logic             alu_zr_i,
    input  logic             alu_neg_i,

    output logic             busy_o
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_grant_q, last_grant_d;
    logic [3:0]         alu_ctrl_q, alu_ctrl_d;
    logic [WIDTH-1:0]   alu_in1_q, alu_in1_d;
    logic [WIDTH-1:0]   alu_in2_q, alu_in2_d;
    logic [WIDTH-1:0]   resp_data_q, resp_data_d;
    logic               resp_zr_q, resp_zr_d;
    logic               resp_neg_q, resp_neg_d;
    logic               resp_err_q, resp_err_d;

    logic               any_valid;
    logic               grant;
    logic [3:0]         sel_op;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic               op_legal;
    logic               div_zero;
    logic               op_ok;
    logic               is_idle;
    logic               resp_fire;

    // Round-robin grant: on a tie the requester not served last wins.
    always_comb begin
        any_valid = req0_valid_i | req1_valid_i;
        grant     = (req0_valid_i & req1_valid_i) ? ~last_grant_q : req1_valid_i;
        sel_op    = grant ? req1_op_i : req0_op_i;
        sel_a     = grant ? req1_a_i  : req0_a_i;
        sel_b     = grant ? req1_b_i  : req0_b_i;
    end

    // Decode legality of the granted operation; divide/modulo by zero is rejected too.
    always_comb begin
        case (sel_op)
            4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: op_legal = 1'b1;
            default:                                             op_legal = 1'b0;
        endcase
        div_zero = ((sel_op == 4'd5) || (sel_op == 4'd6)) && (sel_b == '0);
        op_ok    = op_legal & ~div_zero;
    end

    // Handshake outputs; ready is only ever offered in IDLE and only to the grantee.
    always_comb begin
        is_idle       = (state_q == StIdle);
        req0_ready_o  = is_idle & any_valid & ~grant;
        req1_ready_o  = is_idle & any_valid & grant;
        resp0_valid_o = (state_q == StResp) & ~owner_q;
        resp1_valid_o = (state_q == StResp) & owner_q;
        resp_fire     = (state_q == StResp) & (owner_q ? resp1_ready_i : resp0_ready_i);
    end

    // Next-state logic for the sequencing FSM and its datapath registers.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        alu_ctrl_d   = alu_ctrl_q;
        alu_in1_d    = alu_in1_q;
        alu_in2_d    = alu_in2_q;
        resp_data_d  = resp_data_q;
        resp_zr_d    = resp_zr_q;
        resp_neg_d   = resp_neg_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            StIdle: begin
                if (any_valid) begin
                    owner_d      = grant;
                    last_grant_d = grant;
                    if (op_ok) begin
                        alu_ctrl_d = sel_op;
                        alu_in1_d  = sel_a;
                        alu_in2_d  = sel_b;
                        state_d    = StIssue;
                    end else begin
                        // Rejected: ALU operands untouched, answer straight away.
                        resp_data_d = '0;
                        resp_zr_d   = 1'b0;
                        resp_neg_d  = 1'b0;
                        resp_err_d  = 1'b1;
                        state_d     = StResp;
                    end
                end
            end
            // One cycle for the ALU to register stable operands.
            StIssue: state_d = StWait;
            StWait: begin
                resp_data_d = alu_out_i;
                resp_zr_d   = alu_zr_i;
                resp_neg_d  = alu_neg_i;
                resp_err_d  = 1'b0;
                state_d     = StResp;
            end
            StResp: begin
                if (resp_fire) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any in-flight operation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            alu_ctrl_q   <= '0;
            alu_in1_q    <= '0;
            alu_in2_q    <= '0;
            resp_data_q  <= '0;
            resp_zr_q    <= 1'b0;
            resp_neg_q   <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            alu_ctrl_q   <= alu_ctrl_d;
            alu_in1_q    <= alu_in1_d;
            alu_in2_q    <= alu_in2_d;
            resp_data_q  <= resp_data_d;
            resp_zr_q    <= resp_zr_d;
            resp_neg_q   <= resp_neg_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign alu_ctrl_o  = alu_ctrl_q;
    assign alu_in1_o   = alu_in1_q;
    assign alu_in2_o   = alu_in2_q;
    assign resp_data_o = resp_data_q;
    assign resp_zr_o   = resp_zr_q;
    assign resp_neg_o  = resp_neg_q;
    assign resp_err_o  = resp_err_q;
    assign busy_o      = ~is_idle;

endmodule

// File: tb/tb_alu_scheduler.sv
// Testbench for alu_scheduler: directed scenarios plus random traffic, with a
// transaction-level model feeding a scoreboard that a separate monitor drains.
module tb_alu_scheduler;

    localparam int W = 32;

    typedef struct {
        bit          id;
        logic [31:0] data;
        bit          zr;
        bit          neg;
        bit          err;
        int          vis;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rv[2];
    logic [3:0]    rop[2];
    logic [W-1:0]  ra[2];
    logic [W-1:0]  rb[2];
    logic          rdy[2];
    logic          rsv[2];
    logic          rrdy[2];
    logic [W-1:0]  resp_data;
    logic          resp_zr, resp_neg, resp_err;
    logic [3:0]    alu_ctrl;
    logic [W-1:0]  alu_in1, alu_in2, alu_out;
    logic          alu_zr, alu_neg;
    logic          busy;

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    exp_t          sbq[$];

    // Model state (transaction level)
    bit            m_busy = 1'b0;
    bit            m_owner = 1'b0;
    bit            m_last = 1'b1;
    logic [3:0]    m_ctrl = '0;
    logic [W-1:0]  m_in1 = '0;
    logic [W-1:0]  m_in2 = '0;
    int            m_vis = 0;
    bit            pend[2];
    logic [3:0]    p_op[2];
    logic [W-1:0]  p_a[2];
    logic [W-1:0]  p_b[2];
    int            rr_hold = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_scheduler #(.WIDTH(W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req0_valid_i (rv[0]),
        .req0_ready_o (rdy[0]),
        .req0_op_i    (rop[0]),
        .req0_a_i     (ra[0]),
        .req0_b_i     (rb[0]),
        .req1_valid_i (rv[1]),
        .req1_ready_o (rdy[1]),
        .req1_op_i    (rop[1]),
        .req1_a_i     (ra[1]),
        .req1_b_i     (rb[1]),
        .resp0_valid_o(rsv[0]),
        .resp0_ready_i(rrdy[0]),
        .resp1_valid_o(rsv[1]),
        .resp1_ready_i(rrdy[1]),
        .resp_data_o  (resp_data),
        .resp_zr_o    (resp_zr),
        .resp_neg_o   (resp_neg),
        .resp_err_o   (resp_err),
        .alu_ctrl_o   (alu_ctrl),
        .alu_in1_o    (alu_in1),
        .alu_in2_o    (alu_in2),
        .alu_out_i    (alu_out),
        .alu_zr_i     (alu_zr),
        .alu_neg_i    (alu_neg),
        .busy_o       (busy)
    );

    // Reference ALU semantics, computed in 64-bit signed arithmetic.
    function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint x, y, r;
        x = longint'($signed(a));
        y = longint'($signed(b));
        case (op)
            4'd0: r = x + y;
            4'd1: r = x - y;
            4'd2: r = x ^ y;
            4'd4: r = x * y;
            4'd5: r = (y == 0) ? 64'sd0 : x / y;
            4'd6: r = (y == 0) ? 64'sd0 : x % y;
            4'd7: r = x & y;
            4'd8: r = x | y;
            4'd9: r = x << b[4:0];
            default: r = 64'sd0;
        endcase
        return r[W-1:0];
    endfunction

    function automatic bit accepted_ok(input logic [3:0] op, input logic [W-1:0] b);
        bit legal;
        legal = op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
        return legal && !((op == 4'd5 || op == 4'd6) && b == '0);
    endfunction

    // External registered ALU.
    always @(posedge clk) alu_out <= ref_alu(alu_ctrl, alu_in1, alu_in2);
    assign alu_zr  = (alu_out == '0);
    assign alu_neg = alu_out[W-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rdy0"}, 32'(rdy[0]), 32'd0);
        chk({tag, "_rdy1"}, 32'(rdy[1]), 32'd0);
        chk({tag, "_rsv0"}, 32'(rsv[0]), 32'd0);
        chk({tag, "_rsv1"}, 32'(rsv[1]), 32'd0);
        chk({tag, "_data"}, resp_data, 32'd0);
        chk({tag, "_flags"}, {29'd0, resp_zr, resp_neg, resp_err}, 32'd0);
        chk({tag, "_alu_ctrl"}, 32'(alu_ctrl), 32'd0);
        chk({tag, "_alu_in1"}, alu_in1, 32'd0);
        chk({tag, "_alu_in2"}, alu_in2, 32'd0);
    endtask

    task automatic issue(input int i, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        pend[i] = 1'b1;
        p_op[i] = op;
        p_a[i]  = a;
        p_b[i]  = b;
    endtask

    // One clock of stimulus plus model update; decisions are taken at the negedge.
    task automatic step(input bit rnd);
        bit   g, any, ok;
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!pend[i] && rnd && $urandom_range(9) < 5) begin
                pend[i] = 1'b1;
                p_op[i] = 4'($urandom_range(15));
                p_a[i]  = $urandom;
                p_b[i]  = ($urandom_range(3) == 0) ? '0 : $urandom;
                if ($urandom_range(7) == 0) p_a[i] = p_b[i];
            end
            rv[i]  = pend[i];
            rop[i] = pend[i] ? p_op[i] : 4'($urandom);
            ra[i]  = pend[i] ? p_a[i] : $urandom;
            rb[i]  = pend[i] ? p_b[i] : $urandom;
            if (rr_hold > 0) rrdy[i] = 1'b0;
            else if (rnd)    rrdy[i] = ($urandom_range(2) != 0);
            else             rrdy[i] = 1'b1;
        end
        if (rr_hold > 0) rr_hold--;
        #1;
        any = pend[0] | pend[1];
        g   = (pend[0] && pend[1]) ? !m_last : pend[1];
        chk("busy", 32'(busy), 32'(m_busy));
        chk("req0_ready", 32'(rdy[0]), 32'(!m_busy && any && !g));
        chk("req1_ready", 32'(rdy[1]), 32'(!m_busy && any && g));
        chk("alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
        chk("alu_in1", alu_in1, m_in1);
        chk("alu_in2", alu_in2, m_in2);
        if (m_busy) begin
            if (cyc >= m_vis && rrdy[m_owner]) m_busy = 1'b0;
        end else if (any) begin
            ok     = accepted_ok(p_op[g], p_b[g]);
            e.id   = g;
            e.vis  = cyc + (ok ? 3 : 1);
            e.err  = !ok;
            e.data = ok ? ref_alu(p_op[g], p_a[g], p_b[g]) : '0;
            e.zr   = ok && (e.data == '0);
            e.neg  = ok && e.data[W-1];
            sbq.push_back(e);
            if (ok) begin
                m_ctrl = p_op[g];
                m_in1  = p_a[g];
                m_in2  = p_b[g];
            end
            m_busy  = 1'b1;
            m_owner = g;
            m_last  = g;
            m_vis   = e.vis;
            pend[g] = 1'b0;
        end
    endtask

    task automatic drain();
        bit idle;
        idle = 1'b0;
        for (int k = 0; k < 60 && !idle; k++) begin
            step(1'b0);
            idle = !m_busy && !pend[0] && !pend[1];
        end
        chk("drain_idle", 32'(idle), 32'd1);
    endtask

    // Monitor: pops the scoreboard when a response first appears, checks it while held.
    exp_t cur;
    bit   in_resp = 1'b0;
    bit   have_cur = 1'b0;
    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            in_resp  = 1'b0;
            have_cur = 1'b0;
        end else if (rsv[0] || rsv[1]) begin
            if (!in_resp) begin
                in_resp = 1'b1;
                if (sbq.size() == 0) begin
                    chk("unexpected_resp", {30'd0, rsv[1], rsv[0]}, 32'd0);
                    have_cur = 1'b0;
                end else begin
                    cur      = sbq.pop_front();
                    have_cur = 1'b1;
                    chk("resp_latency", cyc, cur.vis);
                end
            end
            if (have_cur) begin
                chk("resp_owner", {30'd0, rsv[1], rsv[0]}, cur.id ? 32'd2 : 32'd1);
                chk("resp_data", resp_data, cur.data);
                chk("resp_flags", {29'd0, resp_zr, resp_neg, resp_err},
                    {29'd0, cur.zr, cur.neg, cur.err});
            end
            if ((rsv[0] && rrdy[0]) || (rsv[1] && rrdy[1])) in_resp = 1'b0;
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; rop[i] = '0; ra[i] = '0; rb[i] = '0; rrdy[i] = 1'b0;
            pend[i] = 1'b0; p_op[i] = '0; p_a[i] = '0; p_b[i] = '0;
        end
        #1;
        check_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Contention from reset: requester 0 wins the first tie.
        issue(0, 4'd1, 32'd30, 32'd15);
        issue(1, 4'd1, 32'd1, 32'd4);
        drain();
        // Single legal op.
        issue(0, 4'd0, 32'd10, 32'd20);
        drain();
        // Rejections: divide by zero, then an illegal code.
        issue(1, 4'd5, 32'd15, 32'd0);
        drain();
        issue(1, 4'd3, 32'd7, 32'd7);
        drain();
        // Sustained tie alternates grants.
        for (int k = 0; k < 3; k++) begin
            issue(0, 4'd0, 32'(k), 32'd1);
            issue(1, 4'd7, 32'hff, 32'(k));
            drain();
        end
        // Backpressure on a multiply while requester 1 waits.
        issue(0, 4'd4, 32'd2, 32'd15);
        issue(1, 4'd0, 32'd1, 32'd1);
        rr_hold = 8;
        drain();

        // Random traffic.
        for (int k = 0; k < 800; k++) step(1'b1);
        drain();

        // Reset while an operation sits in WAIT.
        issue(0, 4'd0, 32'd5, 32'd6);
        step(1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        #1;
        check_zero("abort");
        m_busy = 1'b0; m_last = 1'b1; m_ctrl = '0; m_in1 = '0; m_in2 = '0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        sbq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(0, 4'd2, 32'd1, 32'd1);
        drain();

        @(negedge clk);
        #3;
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
